// File: rtl/eth_gmii_tx_if.sv
// rtl/eth_gmii_tx_if.sv - Avalon-ST byte stream feeding the GMII transmitter
// The source drives the byte and framing flags; the transmitter returns ready.
interface eth_gmii_tx_if;
   logic       S_avalonST_valid;
   logic [7:0] S_avalonST_data;
   logic       S_avalonST_sop;
   logic       S_avalonST_eop;
   logic       S_avalonST_error;
   logic       S_avalonST_ready;

   modport master (
      output S_avalonST_valid,
      output S_avalonST_data,
      output S_avalonST_sop,
      output S_avalonST_eop,
      output S_avalonST_error,
      input  S_avalonST_ready
   );

   modport slave (
      input  S_avalonST_valid,
      input  S_avalonST_data,
      input  S_avalonST_sop,
      input  S_avalonST_eop,
      input  S_avalonST_error,
      output S_avalonST_ready
   );
endinterface

// File: rtl/eth_gmii_tx.sv
// rtl/eth_gmii_tx.sv - GMII transmit MAC: preamble/SFD, padding, CRC-32 FCS, inter-frame gap
// All GMII pins are registered; the next-state logic computes the byte for the following cycle.
module eth_gmii_tx #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int MAX_FRAME    = 1514,
   parameter int IFG_LEN      = 12
) (
   input  logic         Clk,
   input  logic         Rst_n,
   eth_gmii_tx_if.slave s_if,
   output logic [7:0]   Enet_Tx_Data,
   output logic         Enet_Tx_Dv,
   output logic         Enet_Tx_Er,
   output logic         Tx_Done,
   output logic         Tx_Abort
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_SFD   = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_PAD   = 3'd4;
   localparam logic [2:0] ST_FCS   = 3'd5;
   localparam logic [2:0] ST_DRAIN = 3'd6;
   localparam logic [2:0] ST_IFG   = 3'd7;

   localparam logic [2:0]  PRE_LAST = 3'(PREAMBLE_LEN - 1);
   localparam logic [10:0] MIN_L    = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_L    = 11'(MAX_FRAME);
   // The IDLE cycle that accepts the next sop supplies the last idle of the gap.
   localparam logic [3:0]  GAP_EXIT = 4'(IFG_LEN - 2);

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   logic [2:0]  state_q, state_d;
   logic [7:0]  h_data_q, h_data_d;
   logic        h_eop_q, h_eop_d;
   logic        h_err_q, h_err_d;
   logic [10:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [3:0]  gap_q, gap_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  txd_q, txd_d;
   logic        dv_q, dv_d;
   logic        er_q, er_d;
   logic        done_q, done_d;
   logic        abort_q, abort_d;

   logic        ready;
   logic        acc;
   logic [10:0] cnt_inc;
   logic [31:0] crc_inv;

   always_comb begin
      ready = (state_q == ST_IDLE) || (state_q == ST_DRAIN) ||
              ((state_q == ST_DATA) && !h_eop_q);
   end

   assign s_if.S_avalonST_ready = ready;
   assign acc     = s_if.S_avalonST_valid && ready;
   assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
   assign crc_inv = ~crc_q;

   always_comb begin
      state_d  = state_q;
      h_data_d = h_data_q;
      h_eop_d  = h_eop_q;
      h_err_d  = h_err_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      crc_d    = crc_q;
      txd_d    = 8'h00;
      dv_d     = 1'b0;
      er_d     = 1'b0;
      done_d   = 1'b0;
      abort_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (acc && s_if.S_avalonST_sop) begin
               h_data_d = s_if.S_avalonST_data;
               h_eop_d  = s_if.S_avalonST_eop;
               h_err_d  = s_if.S_avalonST_error;
               cnt_d    = 11'd0;
               idx_d    = 3'd0;
               crc_d    = 32'hFFFFFFFF;
               state_d  = ST_PRE;
            end
         end
         ST_PRE: begin
            txd_d = 8'h55;
            dv_d  = 1'b1;
            if (idx_q == PRE_LAST) begin
               idx_d   = 3'd0;
               state_d = ST_SFD;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         ST_SFD: begin
            txd_d   = 8'hD5;
            dv_d    = 1'b1;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            txd_d = h_data_q;
            dv_d  = 1'b1;
            er_d  = h_err_q;
            crc_d = crc_byte(crc_q, h_data_q);
            cnt_d = cnt_inc;
            if (acc) begin
               h_data_d = s_if.S_avalonST_data;
               h_eop_d  = s_if.S_avalonST_eop;
               h_err_d  = s_if.S_avalonST_error;
            end
            // Oversize, underrun and a stray sop all poison the byte on the wire and abort.
            if ((cnt_inc > MAX_L) ||
                (!h_eop_q && (!s_if.S_avalonST_valid || s_if.S_avalonST_sop))) begin
               er_d    = 1'b1;
               abort_d = 1'b1;
               state_d = (h_eop_q || (acc && s_if.S_avalonST_eop)) ? ST_IFG : ST_DRAIN;
            end else if (h_eop_q) begin
               idx_d   = 3'd0;
               state_d = (cnt_inc < MIN_L) ? ST_PAD : ST_FCS;
            end
         end
         ST_PAD: begin
            dv_d  = 1'b1;
            crc_d = crc_byte(crc_q, 8'h00);
            cnt_d = cnt_inc;
            if (cnt_inc >= MIN_L) begin
               idx_d   = 3'd0;
               state_d = ST_FCS;
            end
         end
         ST_FCS: begin
            txd_d = crc_inv[{idx_q[1:0], 3'b000} +: 8];
            dv_d  = 1'b1;
            if (idx_q[1:0] == 2'd3) begin
               done_d  = 1'b1;
               state_d = ST_IFG;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         ST_DRAIN: begin
            if (acc && s_if.S_avalonST_eop) begin
               state_d = ST_IFG;
            end
         end
         ST_IFG: begin
            if (gap_q >= GAP_EXIT) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Idle cycles on the wire since the last Dv=1 byte.
      if (dv_d) begin
         gap_d = 4'd0;
      end else begin
         gap_d = (gap_q == 4'hF) ? gap_q : gap_q + 4'd1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= ST_IDLE;
         h_data_q <= 8'h00;
         h_eop_q  <= 1'b0;
         h_err_q  <= 1'b0;
         cnt_q    <= 11'd0;
         idx_q    <= 3'd0;
         gap_q    <= 4'd0;
         crc_q    <= 32'hFFFFFFFF;
         txd_q    <= 8'h00;
         dv_q     <= 1'b0;
         er_q     <= 1'b0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_data_q <= h_data_d;
         h_eop_q  <= h_eop_d;
         h_err_q  <= h_err_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         gap_q    <= gap_d;
         crc_q    <= crc_d;
         txd_q    <= txd_d;
         dv_q     <= dv_d;
         er_q     <= er_d;
         done_q   <= done_d;
         abort_q  <= abort_d;
      end
   end

   assign Enet_Tx_Data = txd_q;
   assign Enet_Tx_Dv   = dv_q;
   assign Enet_Tx_Er   = er_q;
   assign Tx_Done      = done_q;
   assign Tx_Abort     = abort_q;

endmodule

// File: tb/tb_eth_gmii_tx.sv
// tb/tb_eth_gmii_tx.sv - directed frame table and corner sequences for eth_gmii_tx
// Frames are rebuilt by a reference model and the received FCS is also checked by CRC residue.
module tb_eth_gmii_tx;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic [7:0] tx_data;
   logic       tx_dv, tx_er, tx_done, tx_abort;

   always #4 Clk = ~Clk;

   eth_gmii_tx_if bus ();

   eth_gmii_tx dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .s_if         (bus),
      .Enet_Tx_Data (tx_data),
      .Enet_Tx_Dv   (tx_dv),
      .Enet_Tx_Er   (tx_er),
      .Tx_Done      (tx_done),
      .Tx_Abort     (tx_abort)
   );

   typedef struct {
      string name;
      int    len;
      int    err_idx;
      int    drop_after;
      int    exp_dv;
      int    exp_er_pos;
      int    exp_done;
      int    exp_abort;
   } vec_t;

   int errors = 0;
   int checks = 0;

   logic [7:0] rec_d[$];
   bit         rec_dv[$];
   bit         rec_er[$];
   int         done_n = 0;
   int         abort_n = 0;
   int         inv_bad = 0;

   always @(negedge Clk) begin
      rec_d.push_back(tx_data);
      rec_dv.push_back(tx_dv);
      rec_er.push_back(tx_er);
      if (tx_done) done_n++;
      if (tx_abort) abort_n++;
      if ((tx_er && !tx_dv) || (!tx_dv && tx_data != 8'h00) || (tx_done && !tx_dv)) inv_bad++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input int len, input int err_idx, input int drop,
                               input int dv, input int er_pos, input int done, input int abrt);
      vec_t v;
      v.name = n; v.len = len; v.err_idx = err_idx; v.drop_after = drop;
      v.exp_dv = dv; v.exp_er_pos = er_pos; v.exp_done = done; v.exp_abort = abrt;
      return v;
   endfunction

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 13 + 90) & 255);
   endfunction

   function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in;
      for (int b = 0; b < 8; b++) begin
         if (c[0] ^ d[b]) c = (c >> 1) ^ 32'hEDB88320;
         else c = c >> 1;
      end
      return c;
   endfunction

   task automatic idle_bus();
      bus.S_avalonST_valid = 1'b0;
      bus.S_avalonST_data  = 8'h00;
      bus.S_avalonST_sop   = 1'b0;
      bus.S_avalonST_eop   = 1'b0;
      bus.S_avalonST_error = 1'b0;
   endtask

   // Entered just after a falling edge; returns just after the falling edge following the transfer.
   task automatic drive_byte(input logic [7:0] d, input bit sop, input bit eop, input bit err,
                             output bit ok);
      bus.S_avalonST_valid = 1'b1;
      bus.S_avalonST_data  = d;
      bus.S_avalonST_sop   = sop;
      bus.S_avalonST_eop   = eop;
      bus.S_avalonST_error = err;
      ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
         if (bus.S_avalonST_ready) ok = 1'b1;
         @(negedge Clk);
      end
   endtask

   task automatic send_frame(input int len, input int err_idx, input int drop_after, output bit ok);
      bit b;
      ok = 1'b1;
      for (int i = 0; i < len; i++) begin
         if (i == drop_after) begin
            idle_bus();
            repeat (4) @(negedge Clk);
         end
         drive_byte(pat(i), i == 0, i == len - 1, i == err_idx, b);
         if (!b) begin
            ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic clear_rec();
      #1;
      rec_d.delete();
      rec_dv.delete();
      rec_er.delete();
      done_n  = 0;
      abort_n = 0;
      inv_bad = 0;
   endtask

   task automatic analyze(input vec_t v);
      logic [7:0]  got[$];
      logic [7:0]  exp[$];
      int          er_n, er_pos, mism;
      logic [31:0] c;
      er_n = 0; er_pos = -1; mism = 0;
      for (int i = 0; i < rec_dv.size(); i++) begin
         if (rec_dv[i]) begin
            got.push_back(rec_d[i]);
            if (rec_er[i]) begin
               er_n++;
               if (er_pos < 0) er_pos = got.size() - 1;
            end
         end
      end
      for (int i = 0; i < 7; i++) exp.push_back(8'h55);
      exp.push_back(8'hD5);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < v.len; i++) begin
         exp.push_back(pat(i));
         c = crc_model(c, pat(i));
      end
      if (v.exp_done != 0) begin
         for (int i = v.len; i < 60; i++) begin
            exp.push_back(8'h00);
            c = crc_model(c, 8'h00);
         end
         c = ~c;
         exp.push_back(c[7:0]);
         exp.push_back(c[15:8]);
         exp.push_back(c[23:16]);
         exp.push_back(c[31:24]);
      end
      for (int k = 0; k < got.size(); k++) begin
         if (k >= exp.size() || got[k] !== exp[k]) mism++;
      end
      check($sformatf("%s dv_cycles", v.name), got.size(), v.exp_dv);
      check($sformatf("%s byte_mismatches", v.name), mism, 0);
      check($sformatf("%s tx_done", v.name), done_n, v.exp_done);
      check($sformatf("%s tx_abort", v.name), abort_n, v.exp_abort);
      check($sformatf("%s er_count", v.name), er_n, (v.exp_er_pos >= 0) ? 1 : 0);
      check($sformatf("%s er_pos", v.name), er_pos, v.exp_er_pos);
      check($sformatf("%s pin_rules", v.name), inv_bad, 0);
      if (v.exp_done != 0) begin
         c = 32'hFFFFFFFF;
         for (int k = 8; k < got.size(); k++) c = crc_model(c, got[k]);
         check($sformatf("%s crc_residue", v.name), c, 32'hDEBB20E3);
      end
   endtask

   task automatic run_vec(input vec_t v);
      bit ok;
      clear_rec();
      send_frame(v.len, v.err_idx, v.drop_after, ok);
      idle_bus();
      check($sformatf("%s handshake", v.name), ok, 1);
      repeat (120) @(negedge Clk);
      analyze(v);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      bit   ok, ok2;
      int   i0, gap, dvn, waited;

      vecs[0] = mk("frame64",   64,   -1, -1, 76,   -1,   1, 0);
      vecs[1] = mk("frame10",   10,   -1, -1, 72,   -1,   1, 0);
      vecs[2] = mk("underrun",  100,  -1, 20, 28,   27,   0, 1);
      vecs[3] = mk("errbyte30", 64,   29, -1, 76,   37,   1, 0);
      vecs[4] = mk("frame60",   60,   -1, -1, 72,   -1,   1, 0);
      vecs[5] = mk("frame59",   59,   -1, -1, 72,   -1,   1, 0);
      vecs[6] = mk("frame1514", 1514, -1, -1, 1526, -1,   1, 0);
      vecs[7] = mk("frame1600", 1600, -1, -1, 1523, 1522, 0, 1);

      idle_bus();
      #10;
      check("reset dv", tx_dv, 0);
      check("reset er", tx_er, 0);
      check("reset data", tx_data, 0);
      check("reset done", tx_done, 0);
      check("reset abort", tx_abort, 0);
      check("reset ready", bus.S_avalonST_ready, 1);
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (3) @(negedge Clk);

      for (int v = 0; v < 8; v++) run_vec(vecs[v]);

      // Back-to-back frames with valid held high between them.
      clear_rec();
      send_frame(64, -1, -1, ok);
      send_frame(64, -1, -1, ok2);
      idle_bus();
      check("b2b handshake", ok && ok2, 1);
      repeat (150) @(negedge Clk);
      dvn = 0;
      foreach (rec_dv[i]) if (rec_dv[i]) dvn++;
      check("b2b dv_cycles", dvn, 152);
      check("b2b tx_done", done_n, 2);
      i0 = -1;
      for (int i = 0; i + 1 < rec_dv.size(); i++) begin
         if (rec_dv[i] && !rec_dv[i + 1]) begin
            i0 = i;
            break;
         end
      end
      gap = 0;
      if (i0 >= 0) for (int j = i0 + 1; j < rec_dv.size() && !rec_dv[j]; j++) gap++;
      check("b2b ifg_cycles", gap, 12);

      // Reset pulse in the middle of the preamble.
      clear_rec();
      drive_byte(pat(0), 1'b1, 1'b0, 1'b0, ok);
      idle_bus();
      check("rst handshake", ok, 1);
      waited = 0;
      while (!tx_dv && waited < 10) begin
         @(negedge Clk);
         waited++;
      end
      check("rst preamble_started", tx_dv, 1);
      @(negedge Clk);
      #2;
      Rst_n = 1'b0;
      #1;
      check("rst async dv", tx_dv, 0);
      check("rst async er", tx_er, 0);
      check("rst async data", tx_data, 0);
      check("rst ready", bus.S_avalonST_ready, 1);
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (20) @(negedge Clk);
      check("rst no_done", done_n, 0);
      check("rst no_abort", abort_n, 0);
      run_vec(mk("after_rst", 64, -1, -1, 76, -1, 1, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
